// File: rtl/aligned_read.sv
// aligned_read: read-burst engine returning byte-lane-placed beats from a word-addressed memory.
// Define ALIGNED_READ_WRAP_EN to support WRAP bursts; without it WRAP answers SLVERR.
module aligned_read (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SEND} state_t;
  state_t      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d, mem_addr_q, mem_addr_d, rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d, len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        err_q, err_d, mem_rd_en_q, mem_rd_en_d, rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d, busy_q, busy_d;
  logic [31:0] szm, inc, nxt, lane_data;
  logic [1:0]  lo, hi;
  logic        start_err, wrap_bad;
`ifdef ALIGNED_READ_WRAP_EN
  logic        wrap_q, wrap_d;
  logic [31:0] wrapm;
  assign wrap_bad = !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                    |(start_addr & ((32'd1 << arsize) - 32'd1));
  assign wrap_d   = (state_q == IDLE && start) ? (arburst == 2'b10 && !start_err) : wrap_q;
  assign wrapm    = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
  assign nxt      = wrap_q ? ((cur_addr_q & ~wrapm) | (inc & wrapm)) : inc;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
`else
  assign wrap_bad = 1'b1;
  assign nxt      = inc;
`endif
  assign szm       = (32'd1 << size_q) - 32'd1;
  assign inc       = (cur_addr_q & ~szm) + szm + 32'd1;
  assign lo        = cur_addr_q[1:0];
  assign hi        = lo | szm[1:0];
  assign start_err = arsize > 3'd2 || arburst == 2'b00 || arburst == 2'b11 ||
                     (arburst == 2'b10 && wrap_bad);
  // Active lanes span from the byte address to the end of its size container
  always_comb
    for (int i = 0; i < 4; i++)
      lane_data[8*i +: 8] = (2'(i) >= lo && 2'(i) <= hi) ? mem_rdata[8*i +: 8] : 8'h00;
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    mem_addr_d  = mem_addr_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    size_d      = size_q;
    rresp_d     = rresp_q;
    err_d       = err_q;
    mem_rd_en_d = 1'b0;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = FETCH;
        cur_addr_d  = start_addr;
        mem_addr_d  = {start_addr[31:2], 2'b00};
        cnt_d       = 8'd0;
        len_d       = arlen;
        size_d      = arsize;
        err_d       = start_err;
        mem_rd_en_d = 1'b1;
        busy_d      = 1'b1;
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        state_d  = SEND;
        rdata_d  = err_q ? 32'd0 : lane_data;
        rresp_d  = err_q ? 2'b10 : 2'b00;
        rlast_d  = cnt_q == len_q;
        rvalid_d = 1'b1;
      end
      SEND: if (rready) begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        if (rlast_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d     = FETCH;
          cur_addr_d  = nxt;
          mem_addr_d  = {nxt[31:2], 2'b00};
          cnt_d       = cnt_q + 8'd1;
          mem_rd_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q     <= IDLE;
      cur_addr_q  <= 32'd0;
      mem_addr_q  <= 32'd0;
      rdata_q     <= 32'd0;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      rresp_q     <= 2'b00;
      err_q       <= 1'b0;
      mem_rd_en_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      mem_addr_q  <= mem_addr_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      size_q      <= size_d;
      rresp_q     <= rresp_d;
      err_q       <= err_d;
      mem_rd_en_q <= mem_rd_en_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      busy_q      <= busy_d;
    end
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rlast     = rlast_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_aligned_read.sv
// tb_aligned_read: directed bursts against aligned_read with a one-cycle-latency word memory.
module tb_aligned_read;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, rready = 1'b1;
  logic [31:0] start_addr = 32'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'b00;
  logic        mem_rd_en, rvalid, rlast, busy;
  logic [31:0] mem_addr, rdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  rresp;
  logic        mem_mode = 1'b0;
  logic [31:0] mem_const = 32'd0, last_addr = 32'd0, held;
  int          rd_cnt = 0, n_chk = 0, n_fail = 0, rd_snap;
  logic        seen;

  aligned_read dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .busy(busy)
  );

  always #5 clk = ~clk;
  // Memory: word returns its own address or a fixed pattern; garbage when not read
  always @(posedge clk) mem_rdata <= mem_rd_en ? (mem_mode ? mem_const : mem_addr) : 32'hDEADBEEF;
  always @(negedge clk) if (mem_rd_en) begin last_addr = mem_addr; rd_cnt++; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    @(negedge clk);
    start_addr = a; arlen = l; arsize = s; arburst = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                      input logic [1:0] er, input logic el);
    for (int i = 0; i < 30 && !rvalid; i++) @(negedge clk);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    if (ea != 32'hFFFF_FFFF) check({tag, "_addr"}, last_addr, ea);
    check({tag, "_rdata"}, rdata, ed);
    check({tag, "_rresp"}, 32'(rresp), 32'(er));
    check({tag, "_rlast"}, 32'(rlast), 32'(el));
    @(negedge clk);
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rden", 32'(mem_rd_en), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp_rlast", {30'd0, rresp[0] | rresp[1], rlast}, 32'd0);
    @(negedge clk) rstn = 1'b1;

    go(32'h100, 8'd3, 3'd2, 2'b01);
    check("incr_busy", 32'(busy), 32'd1);
    beat("incr0", 32'h100, 32'h100, 2'b00, 1'b0);
    beat("incr1", 32'h104, 32'h104, 2'b00, 1'b0);
    beat("incr2", 32'h108, 32'h108, 2'b00, 1'b0);
    beat("incr3", 32'h10C, 32'h10C, 2'b00, 1'b1);
    check("incr_idle", 32'(busy), 32'd0);

    mem_mode = 1'b1; mem_const = 32'hAABBCCDD;
    go(32'h201, 8'd1, 3'd2, 2'b01);
    beat("unal0", 32'h200, 32'hAABBCC00, 2'b00, 1'b0);
    beat("unal1", 32'h204, 32'hAABBCCDD, 2'b00, 1'b1);

    go(32'h601, 8'd1, 3'd1, 2'b01);
    beat("half0", 32'h600, 32'h0000CC00, 2'b00, 1'b0);
    beat("half1", 32'h600, 32'hAABB0000, 2'b00, 1'b1);

    mem_const = 32'h44332211;
    go(32'h302, 8'd2, 3'd0, 2'b01);
    beat("byte0", 32'h300, 32'h00330000, 2'b00, 1'b0);
    beat("byte1", 32'h300, 32'h44000000, 2'b00, 1'b0);
    beat("byte2", 32'h304, 32'h00000011, 2'b00, 1'b1);

    mem_mode = 1'b0;
    rready = 1'b0;
    go(32'h400, 8'd0, 3'd2, 2'b01);
    for (int i = 0; i < 30 && !rvalid; i++) @(negedge clk);
    rd_snap = rd_cnt;
    start_addr = 32'h800; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("stall_rvalid", 32'(rvalid), 32'd1);
      check("stall_rdata", rdata, 32'h400);
      check("stall_rlast", 32'(rlast), 32'd1);
    end
    check("stall_no_rd", 32'(rd_cnt), 32'(rd_snap));
    rready = 1'b1;
    @(negedge clk);
    check("stall_done", {30'd0, rvalid, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("busy_start_ignored", 32'(rd_cnt), 32'(rd_snap));

    rd_snap = rd_cnt;
    go(32'h900, 8'd1, 3'd3, 2'b01);
    beat("size3_0", 32'h900, 32'd0, 2'b10, 1'b0);
    beat("size3_1", 32'h908, 32'd0, 2'b10, 1'b1);
    check("size3_reads", 32'(rd_cnt - rd_snap), 32'd2);
    go(32'hA00, 8'd0, 3'd2, 2'b00);
    beat("burst00", 32'hA00, 32'd0, 2'b10, 1'b1);

`ifdef ALIGNED_READ_WRAP_EN
    go(32'h108, 8'd3, 3'd2, 2'b10);
    beat("wrap0", 32'h108, 32'h108, 2'b00, 1'b0);
    beat("wrap1", 32'h10C, 32'h10C, 2'b00, 1'b0);
    beat("wrap2", 32'h100, 32'h100, 2'b00, 1'b0);
    beat("wrap3", 32'h104, 32'h104, 2'b00, 1'b1);
    go(32'h108, 8'd2, 3'd2, 2'b10);
    beat("wrapbad0", 32'h108, 32'd0, 2'b10, 1'b0);
    beat("wrapbad1", 32'hFFFF_FFFF, 32'd0, 2'b10, 1'b0);
    beat("wrapbad2", 32'hFFFF_FFFF, 32'd0, 2'b10, 1'b1);
`else
    go(32'h108, 8'd3, 3'd2, 2'b10);
    beat("nowrap0", 32'h108, 32'd0, 2'b10, 1'b0);
    beat("nowrap1", 32'hFFFF_FFFF, 32'd0, 2'b10, 1'b0);
    beat("nowrap2", 32'hFFFF_FFFF, 32'd0, 2'b10, 1'b0);
    beat("nowrap3", 32'hFFFF_FFFF, 32'd0, 2'b10, 1'b1);
`endif

    go(32'hFFFFFFFC, 8'd1, 3'd2, 2'b01);
    beat("addrwrap0", 32'hFFFFFFFC, 32'hFFFFFFFC, 2'b00, 1'b0);
    beat("addrwrap1", 32'h0, 32'h0, 2'b00, 1'b1);

    go(32'h500, 8'd7, 3'd2, 2'b01);
    beat("rstmid0", 32'h500, 32'h500, 2'b00, 1'b0);
    @(negedge clk);
    held = rdata;
    check("rstmid_pre_rdata", held, 32'h500);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rvalid", 32'(rvalid), 32'd0);
    check("rstmid_rdata", rdata, 32'd0);
    check("rstmid_maddr", mem_addr, 32'd0);
    check("rstmid_rden_rlast", {30'd0, mem_rd_en, rlast}, 32'd0);
    @(negedge clk) rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen |= rvalid | busy | mem_rd_en;
    end
    check("rstmid_quiet", 32'(seen), 32'd0);
    go(32'h700, 8'd0, 3'd2, 2'b01);
    beat("recover", 32'h700, 32'h700, 2'b00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aligned_read.md
ALIGNED_READ -- requirements
Module: aligned_read

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports start input 1 (burst request pulse), start_addr input 32, arlen input 8 (beats-1), arsize input 3 (log2 bytes/beat), arburst input 2 (01 INCR, 10 WRAP).
REQ-004 SHALL have ports mem_rd_en output 1, mem_addr output 32 (word-aligned, bits[1:0]=0), mem_rdata input 32 (valid exactly one cycle after mem_rd_en).
REQ-005 SHALL have ports rvalid output 1, rready input 1, rdata output 32, rresp output 2, rlast output 1, busy output 1.

Function
REQ-006 SHALL implement states IDLE, FETCH, CAPTURE, SEND; busy=1 in every state except IDLE.
REQ-007 IDLE: start=1 latches start_addr, arlen, arsize, arburst, clears beat counter, next state FETCH; start outside IDLE SHALL be ignored.
REQ-008 FETCH: mem_rd_en=1 for exactly one cycle, mem_addr={cur_addr[31:2],2'b00}; next state CAPTURE.
REQ-009 CAPTURE: mem_rdata registered into the beat buffer at the closing edge; next state SEND.
REQ-010 SEND: rvalid=1 and rdata/rresp/rlast SHALL hold stable until rready=1; rvalid SHALL not depend combinationally on rready.
REQ-011 Handshake (rvalid&rready): last beat -> IDLE; otherwise update cur_addr, increment beat counter, -> FETCH; minimum beat period 3 cycles.
REQ-012 Lane placement: active lanes run from cur_addr[1:0] to the end of the (1<<arsize)-byte container holding cur_addr; rdata active lanes = mem_rdata same lanes, inactive lanes SHALL be 0.
REQ-013 Unaligned first beat (e.g. addr[1:0]=01, arsize=2) SHALL return only lanes 1..3; subsequent beats are size-aligned.
REQ-014 INCR: next cur_addr = (cur_addr & ~((1<<arsize)-1)) + (1<<arsize), 32-bit wrap-around at 0xFFFFFFFF without error.
REQ-015 rlast=1 only on beat with counter == latched arlen; burst of arlen+1 beats exactly.
REQ-016 rresp=00 normally; arsize>2 or arburst in {00,11} SHALL give rresp=10 (SLVERR) and rdata=0 on every beat, beat count unchanged, memory still read.
REQ-017 Beat buffer SHALL be overwritten only in CAPTURE.

Reset
REQ-018 rstn low SHALL immediately force IDLE, mem_rd_en=0, mem_addr=0, rvalid=0, rdata=0, rresp=0, rlast=0, busy=0, counter and latched parameters 0.
REQ-019 Reset mid-burst SHALL abandon the burst; no further beats after rstn releases until a new start.

Configuration
REQ-020 Macro ALIGNED_READ_WRAP_EN defined: arburst=10 SHALL wrap; boundary = (arlen+1)<<arsize, legal arlen in {1,3,7,15}, start_addr must be size-aligned, address wraps to boundary base when incremented address reaches base+boundary.
REQ-021 ALIGNED_READ_WRAP_EN defined: WRAP with illegal arlen or unaligned start_addr SHALL give SLVERR per REQ-016.
REQ-022 ALIGNED_READ_WRAP_EN undefined: arburst=10 SHALL be treated as unsupported per REQ-016; no wrap logic present.

Verification
REQ-023 start_addr=0x100, arlen=3, arsize=2, INCR, rready=1, mem word=addr -> mem_addr 0x100,0x104,0x108,0x10C; rdata equal; rlast on 4th beat; rresp=00.
REQ-024 start_addr=0x201, arlen=1, arsize=2, mem_rdata=0xAABBCCDD -> beat0 rdata=0xAABBCC00, beat1 mem_addr 0x204 rdata=0xAABBCCDD.
REQ-025 start_addr=0x302, arsize=0, arlen=2, mem_rdata=0x44332211 -> rdata 0x00330000, 0x44000000, then mem_addr 0x304 rdata 0x00000011.
REQ-026 rready held 0 for 5 cycles in SEND -> rvalid/rdata/rlast stable, no mem_rd_en issued; single handshake after release.
REQ-027 (WRAP_EN) start_addr=0x108, arlen=3, arsize=2, WRAP -> mem_addr 0x108,0x10C,0x100,0x104; without macro -> 4 beats rresp=10 rdata=0.
REQ-028 rstn pulsed low during beat 2 of 8 -> outputs 0 asynchronously, busy=0, no rvalid until next start.
